wb_data_arbiter: RTL and testbench
==================================

Name: wb_data_arbiter

Overview:
- Two-master, one-slave arbiter for the pipelined Wishbone data-memory port.
- Master 0 is the core's memory-access stage (cyc/req/we/addr/wdata/be, ack/stall/rdata). Master 1 is a secondary requester, such as a debug module or DMA engine.
- Grants the slave port to one master per bus cycle and forwards its requests.
- Routes acks and read data back to the granted master and tracks outstanding requests, so a grant is never released with responses still in flight.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unacknowledged requests; must be 1..7.
- ROUND_ROBIN, 1, 1 = round-robin on contention, 0 = fixed priority with master 0 winning.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- m0_cyc_i, m1_cyc_i  in  1  bus cycle active for master n.
- m0_req_i, m1_req_i  in  1  request strobe for master n.
- m0_we_i, m1_we_i  in  1  write enable for master n.
- m0_addr_i, m1_addr_i  in  ADDR_WIDTH  address for master n.
- m0_wdata_i, m1_wdata_i  in  DATA_WIDTH  write data for master n.
- m0_be_i, m1_be_i  in  DATA_WIDTH/8  byte enables for master n.
- m0_ack_o, m1_ack_o  out  1  ack forwarded to master n.
- m0_stall_o, m1_stall_o  out  1  stall to master n.
- m0_rdata_o, m1_rdata_o  out  DATA_WIDTH  read data to master n.
- s_cyc_o, s_req_o, s_we_o  out  1  slave cycle, strobe and write enable.
- s_addr_o  out  ADDR_WIDTH  slave address.
- s_wdata_o  out  DATA_WIDTH  slave write data.
- s_be_o  out  DATA_WIDTH/8  slave byte enables.
- s_ack_i, s_stall_i  in  1  slave ack and stall.
- s_rdata_i  in  DATA_WIDTH  slave read data.
- grant_o  out  2  one-hot current grant: bit0 = master 0, bit1 = master 1; 00 = idle.
- busy_o  out  1  high when outstanding count is nonzero.

Behaviour:
- Clock and reset: single clock clk; rstn asynchronous active-low.
- Reset values:
  - state = IDLE, outstanding count = 0, last_grant = master 1 (so master 0 wins the first tie).
  - All s_* outputs 0, all m*_ack_o 0, all m*_stall_o 1, grant_o = 00, busy_o = 0.
  - m*_rdata_o are routed straight from s_rdata_i and have no reset value.
- States: IDLE, GNT0, GNT1. State and counter are registered; all forwarding paths are combinational from the current state.
- IDLE:
  - No requester: stay in IDLE.
  - Exactly one cyc high: move to that master's grant state.
  - Both cyc high: ROUND_ROBIN=1 grants the master not equal to last_grant; ROUND_ROBIN=0 grants master 0.
  - Outputs: s_cyc_o = s_req_o = 0; both masters see stall = 1. Arbitration costs exactly one cycle.
- GNTn forwarding:
  - s_cyc_o = mn_cyc_i.
  - s_req_o = mn_req_i && count < MAX_OUTSTANDING.
  - s_we_o, s_addr_o, s_wdata_o, s_be_o are muxed from master n.
  - mn_stall_o = s_stall_i || count == MAX_OUTSTANDING.
  - mn_ack_o = s_ack_i && count != 0.
  - The other master sees stall = 1 and ack = 0.
  - In all states, rdata to both masters equals s_rdata_i; it is qualified by ack.
- Counter: accept = s_req_o && !s_stall_i.
  - accept without ack: +1; ack without accept: -1; both or neither: unchanged.
  - An ack with count = 0 is spurious: not forwarded, count stays 0.
- Release (GNTn, mn_cyc_i low):
  - count = 0: go to the other master's grant if its cyc is high, else IDLE. This is a zero-bubble handoff.
  - count > 0: this is an abort. Clear count and go to IDLE for at least one cycle; any ack in that IDLE cycle is discarded.
  - last_grant updates to n on every exit from GNTn.
- Retention: the grant is never revoked while mn_cyc_i is high. Master n holds the bus for its whole cycle, with no preemption.
- Reset asserted mid-transaction: immediate return to reset values; in-flight acks are lost.

Test Plan:
- Single master 0 read: m0_cyc = req = 1, addr = 0x100, we = 0.
  - Cycle 1: stall = 1, state IDLE→GNT0.
  - Cycle 2: s_req = 1, s_addr = 0x100.
  - Slave ack with rdata = 0xDEADBEEF → m0_ack = 1, m0_rdata = 0xDEADBEEF, busy_o back to 0.
- Simultaneous cyc from both masters after reset, ROUND_ROBIN=1:
  - grant_o = 01 first.
  - After m0 drops cyc with count = 0: grant_o = 10 on the next cycle with no IDLE bubble.
  - Repeat contention → master 0 wins again.
- Outstanding limit: master 1 issues 3 back-to-back writes, be = 0xF, slave acks late, MAX_OUTSTANDING = 2.
  - After 2 accepts: m1_stall = 1, s_req = 0.
  - First ack → third write accepted; count never exceeds 2.
- Abort: master 0 drops cyc with count = 1.
  - s_cyc_o falls the same cycle, state → IDLE, count → 0.
  - Slave ack that cycle → m0_ack = m1_ack = 0.
- Spurious ack: s_ack_i = 1 while count = 0 in GNT0 → m0_ack = 0, count stays 0.
- Fixed priority, ROUND_ROBIN=0: both cyc high in IDLE on every contention → always GNT0.

Source files
------------

// File: rtl/wb_data_arbiter.sv
// Two-master, one-slave arbiter for the pipelined Wishbone data-memory port.
// Master 0 is the memory-access stage, master 1 a secondary requester (debug/DMA).
module wb_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    m0_cyc_i,
    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    output logic                    m0_ack_o,
    output logic                    m0_stall_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    output logic                    m1_ack_o,
    output logic                    m1_stall_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_cyc_o,
    output logic                    s_req_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    input  logic                    s_ack_i,
    input  logic                    s_stall_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic [1:0]              grant_o,
    output logic                    busy_o
);

    localparam int         BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    // last_q = 1'b1 means master 1 held the bus most recently
    logic       last_q, last_d;
    logic       accept_s;
    logic       ack_fwd_s;

    // Response data needs no muxing: only the acked master samples it.
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;
    assign busy_o     = (cnt_q != 3'd0);

    // Request/response forwarding for the currently granted master
    always_comb begin
        s_cyc_o    = 1'b0;
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = {ADDR_WIDTH{1'b0}};
        s_wdata_o  = {DATA_WIDTH{1'b0}};
        s_be_o     = {BE_WIDTH{1'b0}};
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        grant_o    = 2'b00;
        case (state_q)
            GNT0: begin
                s_cyc_o    = m0_cyc_i;
                s_req_o    = m0_req_i && (cnt_q < MAX_CNT);
                s_we_o     = m0_we_i;
                s_addr_o   = m0_addr_i;
                s_wdata_o  = m0_wdata_i;
                s_be_o     = m0_be_i;
                m0_stall_o = s_stall_i || (cnt_q == MAX_CNT);
                m0_ack_o   = s_ack_i && (cnt_q != 3'd0);
                grant_o    = 2'b01;
            end
            GNT1: begin
                s_cyc_o    = m1_cyc_i;
                s_req_o    = m1_req_i && (cnt_q < MAX_CNT);
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_wdata_o  = m1_wdata_i;
                s_be_o     = m1_be_i;
                m1_stall_o = s_stall_i || (cnt_q == MAX_CNT);
                m1_ack_o   = s_ack_i && (cnt_q != 3'd0);
                grant_o    = 2'b10;
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

    assign accept_s  = s_req_o && !s_stall_i;
    assign ack_fwd_s = m0_ack_o || m1_ack_o;

    // Arbitration, release handling and outstanding-request tracking
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (accept_s && !ack_fwd_s) begin
            cnt_d = cnt_q + 3'd1;
        end else if (ack_fwd_s && !accept_s) begin
            cnt_d = cnt_q - 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (m0_cyc_i && m1_cyc_i) begin
                    if ((ROUND_ROBIN != 0) && !last_q) begin
                        state_d = GNT1;
                    end else begin
                        state_d = GNT0;
                    end
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    // Release with responses pending is an abort: force an IDLE cycle.
                    last_d = 1'b0;
                    cnt_d  = 3'd0;
                    if ((cnt_q == 3'd0) && m1_cyc_i) begin
                        state_d = GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_d = 1'b1;
                    cnt_d  = 3'd0;
                    if ((cnt_q == 3'd0) && m0_cyc_i) begin
                        state_d = GNT0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = GNT1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, counter and last-grant registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Self-checking bench for wb_data_arbiter: per-cycle vector table run through a
// scoreboard queue, plus a fixed-priority contention sequence.
module tb_wb_data_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_cyc = 1'b0, m0_req = 1'b0, m0_we = 1'b0;
    logic        m1_cyc = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0, m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_be = 4'h0, m1_be = 4'h0;
    logic        s_ack = 1'b0, s_stall = 1'b0;
    logic [31:0] s_rdata = 32'h0;

    logic        m0_ack, m0_stall, m1_ack, m1_stall, s_cyc, s_req, s_we, busy;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_be;
    logic [1:0]  grant;

    logic        f_m0_ack, f_m0_stall, f_m1_ack, f_m1_stall, f_s_cyc, f_s_req, f_s_we, f_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
    logic [3:0]  f_s_be;
    logic [1:0]  f_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rstn(rstn),
        .m0_cyc_i(m0_cyc), .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
        .m0_rdata_o(m0_rdata),
        .m1_cyc_i(m1_cyc), .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be), .m1_ack_o(m1_ack), .m1_stall_o(m1_stall),
        .m1_rdata_o(m1_rdata),
        .s_cyc_o(s_cyc), .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_be_o(s_be), .s_ack_i(s_ack), .s_stall_i(s_stall),
        .s_rdata_i(s_rdata), .grant_o(grant), .busy_o(busy)
    );

    wb_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rstn(rstn),
        .m0_cyc_i(m0_cyc), .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be), .m0_ack_o(f_m0_ack), .m0_stall_o(f_m0_stall),
        .m0_rdata_o(f_m0_rdata),
        .m1_cyc_i(m1_cyc), .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be), .m1_ack_o(f_m1_ack), .m1_stall_o(f_m1_stall),
        .m1_rdata_o(f_m1_rdata),
        .s_cyc_o(f_s_cyc), .s_req_o(f_s_req), .s_we_o(f_s_we), .s_addr_o(f_s_addr),
        .s_wdata_o(f_s_wdata), .s_be_o(f_s_be), .s_ack_i(s_ack), .s_stall_i(s_stall),
        .s_rdata_i(s_rdata), .grant_o(f_grant), .busy_o(f_busy)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  cyc, req, we;
        logic [31:0] addr0, addr1;
        logic        ack, stall;
        logic [31:0] rdata;
        logic [1:0]  e_grant;
        logic        e_scyc, e_sreq;
        logic [1:0]  e_mstall, e_mack;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(string name, logic rst, logic [1:0] cyc, logic [1:0] req,
                                logic [1:0] we, logic [31:0] addr0, logic [31:0] addr1,
                                logic ack, logic stall, logic [31:0] rdata,
                                logic [1:0] e_grant, logic e_scyc, logic e_sreq,
                                logic [1:0] e_mstall, logic [1:0] e_mack, logic e_busy);
        vec_t v;
        v.name = name; v.rst = rst; v.cyc = cyc; v.req = req; v.we = we;
        v.addr0 = addr0; v.addr1 = addr1; v.ack = ack; v.stall = stall; v.rdata = rdata;
        v.e_grant = e_grant; v.e_scyc = e_scyc; v.e_sreq = e_sreq;
        v.e_mstall = e_mstall; v.e_mack = e_mack; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string row, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", row, what, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        if (v.rst) begin
            rstn = 1'b0;
            #1;
            rstn = 1'b1;
        end
        m0_cyc = v.cyc[0]; m1_cyc = v.cyc[1];
        m0_req = v.req[0]; m1_req = v.req[1];
        m0_we = v.we[0];   m1_we = v.we[1];
        m0_addr = v.addr0; m1_addr = v.addr1;
        m0_wdata = ~v.addr0; m1_wdata = ~v.addr1;
        m0_be = 4'h3; m1_be = 4'hF;
        s_ack = v.ack; s_stall = v.stall; s_rdata = v.rdata;
    endtask

    task automatic check_row(input vec_t v);
        logic [31:0] ea, ed;
        logic        ew;
        logic [3:0]  eb;
        case (v.e_grant)
            2'b01:   begin ea = v.addr0; ed = ~v.addr0; ew = v.we[0]; eb = 4'h3; end
            2'b10:   begin ea = v.addr1; ed = ~v.addr1; ew = v.we[1]; eb = 4'hF; end
            default: begin ea = 32'h0;   ed = 32'h0;    ew = 1'b0;   eb = 4'h0; end
        endcase
        chk(v.name, "grant", {30'h0, grant}, {30'h0, v.e_grant});
        chk(v.name, "s_cyc", {31'h0, s_cyc}, {31'h0, v.e_scyc});
        chk(v.name, "s_req", {31'h0, s_req}, {31'h0, v.e_sreq});
        chk(v.name, "stall", {30'h0, m1_stall, m0_stall}, {30'h0, v.e_mstall});
        chk(v.name, "ack", {30'h0, m1_ack, m0_ack}, {30'h0, v.e_mack});
        chk(v.name, "busy", {31'h0, busy}, {31'h0, v.e_busy});
        chk(v.name, "s_addr", s_addr, ea);
        chk(v.name, "s_wdata", s_wdata, ed);
        chk(v.name, "s_we", {31'h0, s_we}, {31'h0, ew});
        chk(v.name, "s_be", {28'h0, s_be}, {28'h0, eb});
        if (v.e_mack[0]) chk(v.name, "m0_rdata", m0_rdata, v.rdata);
        if (v.e_mack[1]) chk(v.name, "m1_rdata", m1_rdata, v.rdata);
    endtask

    // Fixed-priority sequence: cyc pattern, expected grant for RR=0 and RR=1 instances
    logic [1:0] fp_cyc [10] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
    logic [1:0] fp_exp [10] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    logic [1:0] rr_exp [10] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};

    initial begin
        // name rst cyc req we addr0 addr1 ack stall rdata | grant scyc sreq mstall mack busy
        tbl.push_back(mk("reset",    1'b1, 2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("m0_arb",   1'b0, 2'b01, 2'b01, 2'b00, 32'h100, 32'h0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("m0_req",   1'b0, 2'b01, 2'b01, 2'b00, 32'h100, 32'h0,   1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("m0_ack",   1'b0, 2'b01, 2'b00, 2'b00, 32'h100, 32'h0,   1'b1, 1'b0, 32'hDEADBEEF, 2'b01, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1));
        tbl.push_back(mk("m0_done",  1'b0, 2'b01, 2'b00, 2'b00, 32'h100, 32'h0,   1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("spur_ack", 1'b0, 2'b01, 2'b00, 2'b00, 32'h100, 32'h0,   1'b1, 1'b0, 32'h5A5A5A5A, 2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("spur_cnt", 1'b0, 2'b01, 2'b00, 2'b00, 32'h100, 32'h0,   1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("m0_rel",   1'b0, 2'b00, 2'b00, 2'b00, 32'h100, 32'h0,   1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("idle",     1'b0, 2'b00, 2'b00, 2'b00, 32'h100, 32'h0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("cont",     1'b1, 2'b11, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("cont_g0",  1'b0, 2'b11, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("m0_drop",  1'b0, 2'b10, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("handoff",  1'b0, 2'b10, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("m1_drop",  1'b0, 2'b00, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b10, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("cont2",    1'b0, 2'b11, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("cont2_g0", 1'b0, 2'b11, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("m0_drop2", 1'b0, 2'b00, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("cont3",    1'b0, 2'b11, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("cont3_g1", 1'b0, 2'b11, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("rel3",     1'b0, 2'b00, 2'b00, 2'b00, 32'h110, 32'h210, 1'b0, 1'b0, 32'h0,        2'b10, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("ost_arb",  1'b1, 2'b10, 2'b10, 2'b10, 32'h0,   32'h200, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("ost_w1",   1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h200, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("ost_w2",   1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h204, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1));
        tbl.push_back(mk("ost_full", 1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h208, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1));
        tbl.push_back(mk("ost_ack1", 1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h208, 1'b1, 1'b0, 32'h11,       2'b10, 1'b1, 1'b0, 2'b11, 2'b10, 1'b1));
        tbl.push_back(mk("ost_w3",   1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h208, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1));
        tbl.push_back(mk("ost_ack2", 1'b0, 2'b10, 2'b00, 2'b10, 32'h0,   32'h208, 1'b1, 1'b0, 32'h22,       2'b10, 1'b1, 1'b0, 2'b11, 2'b10, 1'b1));
        tbl.push_back(mk("ost_both", 1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h20C, 1'b1, 1'b0, 32'h33,       2'b10, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1));
        tbl.push_back(mk("ost_ack3", 1'b0, 2'b10, 2'b00, 2'b10, 32'h0,   32'h20C, 1'b1, 1'b0, 32'h44,       2'b10, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1));
        tbl.push_back(mk("ost_empty",1'b0, 2'b10, 2'b00, 2'b10, 32'h0,   32'h20C, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("sl_stall", 1'b0, 2'b10, 2'b10, 2'b10, 32'h0,   32'h210, 1'b0, 1'b1, 32'h0,        2'b10, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("sl_nocnt", 1'b0, 2'b10, 2'b00, 2'b10, 32'h0,   32'h210, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("ab_arb",   1'b1, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("ab_req",   1'b0, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0,   1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("ab_drop",  1'b0, 2'b10, 2'b00, 2'b00, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1));
        tbl.push_back(mk("ab_idle",  1'b0, 2'b10, 2'b00, 2'b00, 32'h300, 32'h400, 1'b1, 1'b0, 32'h77,       2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("ab_g1",    1'b0, 2'b10, 2'b00, 2'b00, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("mid_req",  1'b0, 2'b10, 2'b10, 2'b00, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("mid_rst",  1'b1, 2'b10, 2'b00, 2'b00, 32'h300, 32'h400, 1'b1, 1'b0, 32'h88,       2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        tbl.push_back(mk("post_rst", 1'b0, 2'b00, 2'b00, 2'b00, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0,        2'b10, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(tbl[i]);
            #1;
            check_row(exp_q.pop_front());
        end

        // Fixed priority vs. round robin on repeated contention
        @(negedge clk);
        apply(mk("fp_rst", 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m0_cyc = fp_cyc[i][0];
            m1_cyc = fp_cyc[i][1];
            #1;
            chk($sformatf("fp%0d", i), "fp_grant", {30'h0, f_grant}, {30'h0, fp_exp[i]});
            chk($sformatf("fp%0d", i), "rr_grant", {30'h0, grant}, {30'h0, rr_exp[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
